// File: rtl/note_decoder_glide.sv
// Note decoder with octave shift and portamento (glide) toward the selected pitch.
// Latency: accepted key / octave change takes effect at the accepting edge; a glide
// steps every GLIDE_TICKS cycles. Backpressure: key_ready_o is low while gliding.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   key_valid_i/_ready_o key handshake; key_value_i 0-11 = C..B, 12 = rest, 13-15 ignored
//   oct_up_i, oct_dn_i   single-cycle octave requests (saturating, both high = no change)
//   glide_en_i           1 = portamento toward new pitch, 0 = immediate load
//   div_factor_o         divide factor for the tone generator
//   note_active_o        a note (not a rest) is sounding
//   busy_o               a glide is in progress
module note_decoder_glide #(
    parameter int DIV_W       = 16,
    parameter int OCT_MAX     = 3,
    parameter int GLIDE_TICKS = 4,
    parameter int GLIDE_STEP  = 16,
    parameter int DEFAULT_DIV = 128
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             key_valid_i,
    input  logic [3:0]       key_value_i,
    output logic             key_ready_o,
    input  logic             oct_up_i,
    input  logic             oct_dn_i,
    input  logic             glide_en_i,
    output logic [DIV_W-1:0] div_factor_o,
    output logic             note_active_o,
    output logic             busy_o
);

    localparam int OCT_W  = (OCT_MAX > 0) ? $clog2(OCT_MAX + 1) : 1;
    localparam int TICK_W = (GLIDE_TICKS > 1) ? $clog2(GLIDE_TICKS) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GLIDE = 1'b1;

    localparam logic [OCT_W-1:0]  OCT_TOP   = OCT_W'(OCT_MAX);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(GLIDE_TICKS - 1);
    localparam logic [DIV_W-1:0]  STEP      = DIV_W'(GLIDE_STEP);
    localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DEFAULT_DIV);

    logic [0:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [OCT_W-1:0]  oct_q, oct_d;
    logic [3:0]        note_q, note_d;
    logic              active_q, active_d;
    logic [TICK_W-1:0] tick_q, tick_d;

    logic              key_acc, acc_note, acc_rest, oct_chg, retarget;
    logic [DIV_W-1:0]  base_ext, target, diff, step_val;

    // Base divide factors at the top octave index, C..B.
    function automatic logic [7:0] base_div(input logic [3:0] n);
        case (n)
            4'd0:    base_div = 8'd240;
            4'd1:    base_div = 8'd227;
            4'd2:    base_div = 8'd214;
            4'd3:    base_div = 8'd202;
            4'd4:    base_div = 8'd190;
            4'd5:    base_div = 8'd180;
            4'd6:    base_div = 8'd170;
            4'd7:    base_div = 8'd160;
            4'd8:    base_div = 8'd151;
            4'd9:    base_div = 8'd143;
            4'd10:   base_div = 8'd135;
            4'd11:   base_div = 8'd127;
            default: base_div = 8'd240;
        endcase
    endfunction

    assign key_ready_o   = (state_q == ST_IDLE);
    assign busy_o        = (state_q == ST_GLIDE);
    assign div_factor_o  = div_q;
    assign note_active_o = active_q;

    assign key_acc  = key_valid_i && key_ready_o;
    assign acc_note = key_acc && (key_value_i < 4'd12);
    assign acc_rest = key_acc && (key_value_i == 4'd12);

    // Saturating octave; simultaneous up and down cancel.
    always_comb begin
        oct_d = oct_q;
        if (oct_up_i && !oct_dn_i && (oct_q != OCT_TOP)) begin
            oct_d = oct_q + OCT_W'(1);
        end else if (oct_dn_i && !oct_up_i && (oct_q != '0)) begin
            oct_d = oct_q - OCT_W'(1);
        end
    end

    assign oct_chg  = (oct_d != oct_q);
    assign note_d   = acc_note ? key_value_i : note_q;
    assign active_d = acc_note ? 1'b1 : (acc_rest ? 1'b0 : active_q);

    // A rest on the same edge as an octave change silences the note, so no retarget.
    assign retarget = acc_note || (oct_chg && active_q && !acc_rest);

    // Target always reflects the post-edge note and octave.
    assign base_ext = {{(DIV_W-8){1'b0}}, base_div(note_d)};
    assign target   = (base_ext << OCT_MAX) >> oct_d;

    // One glide step toward target, clamped so it never overshoots.
    always_comb begin
        diff     = (target > div_q) ? (target - div_q) : (div_q - target);
        step_val = target;
        if (diff > STEP) begin
            step_val = (target > div_q) ? (div_q + STEP) : (div_q - STEP);
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tick_d  = tick_q;
        case (state_q)
            ST_IDLE: begin
                if (retarget) begin
                    if (!glide_en_i) begin
                        div_d = target;
                    end else if (target != div_q) begin
                        state_d = ST_GLIDE;
                        tick_d  = '0;
                    end
                end
            end
            ST_GLIDE: begin
                if (!glide_en_i) begin
                    div_d   = target;
                    state_d = ST_IDLE;
                    tick_d  = '0;
                end else if (div_q == target) begin
                    // An octave change can move the target onto the current value.
                    state_d = ST_IDLE;
                    tick_d  = '0;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    div_d  = step_val;
                    if (step_val == target) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            div_q    <= DIV_RST;
            oct_q    <= '0;
            note_q   <= '0;
            active_q <= 1'b0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            oct_q    <= oct_d;
            note_q   <= note_d;
            active_q <= active_d;
            tick_q   <= tick_d;
        end
    end

endmodule

// File: tb/tb_note_decoder_glide.sv
// Bench for note_decoder_glide: directed scenarios then random traffic,
// all checked against a pitch/glide model built from the note rules.
// Runs with default parameters.
module tb_note_decoder_glide;

    localparam int DIV_W       = 16;
    localparam int OCT_MAX     = 3;
    localparam int GLIDE_TICKS = 4;
    localparam int GLIDE_STEP  = 16;
    localparam int DEFAULT_DIV = 128;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             key_valid_i;
    logic [3:0]       key_value_i;
    logic             key_ready_o;
    logic             oct_up_i;
    logic             oct_dn_i;
    logic             glide_en_i;
    logic [DIV_W-1:0] div_factor_o;
    logic             note_active_o;
    logic             busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    note_decoder_glide dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .key_valid_i  (key_valid_i),
        .key_value_i  (key_value_i),
        .key_ready_o  (key_ready_o),
        .oct_up_i     (oct_up_i),
        .oct_dn_i     (oct_dn_i),
        .glide_en_i   (glide_en_i),
        .div_factor_o (div_factor_o),
        .note_active_o(note_active_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state (plain integers).
    int base_tab[12] = '{240, 227, 214, 202, 190, 180, 170, 160, 151, 143, 135, 127};
    int m_div, m_oct, m_note, m_active, m_busy, m_wait;

    function automatic int pitch(input int n, input int o);
        return (base_tab[n] * (1 << OCT_MAX)) / (1 << o);
    endfunction

    task automatic m_reset();
        m_div = DEFAULT_DIV; m_oct = 0; m_note = 0;
        m_active = 0; m_busy = 0; m_wait = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic m_step();
        int new_oct, t, code;
        bit take, retgt;
        new_oct = m_oct;
        if (oct_up_i && !oct_dn_i && m_oct < OCT_MAX) new_oct = m_oct + 1;
        if (oct_dn_i && !oct_up_i && m_oct > 0)       new_oct = m_oct - 1;
        code  = int'(key_value_i);
        take  = key_valid_i && (m_busy == 0);
        retgt = 0;
        if (m_busy == 0) begin
            if (take && code < 12) begin
                m_note = code; m_active = 1; retgt = 1;
            end else if (take && code == 12) begin
                m_active = 0;
            end else if (new_oct != m_oct && m_active == 1) begin
                retgt = 1;
            end
            m_oct = new_oct;
            if (retgt) begin
                t = pitch(m_note, m_oct);
                if (!glide_en_i) m_div = t;
                else if (t != m_div) begin m_busy = 1; m_wait = GLIDE_TICKS; end
            end
        end else begin
            m_oct = new_oct;
            t = pitch(m_note, m_oct);
            if (!glide_en_i) begin
                m_div = t; m_busy = 0;
            end else if (m_div == t) begin
                m_busy = 0;
            end else begin
                m_wait = m_wait - 1;
                if (m_wait == 0) begin
                    if (t > m_div) m_div = (t - m_div <= GLIDE_STEP) ? t : m_div + GLIDE_STEP;
                    else           m_div = (m_div - t <= GLIDE_STEP) ? t : m_div - GLIDE_STEP;
                    m_wait = GLIDE_TICKS;
                    if (m_div == t) m_busy = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".div"},    32'(div_factor_o),  32'(m_div));
        chk({tag, ".active"}, 32'(note_active_o), 32'(m_active));
        chk({tag, ".busy"},   32'(busy_o),        32'(m_busy));
        chk({tag, ".ready"},  32'(key_ready_o),   32'(m_busy == 0));
    endtask

    // One clock edge: model and DUT advance together, outputs sampled 1 ns later.
    task automatic cyc(input string tag);
        m_step();
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        key_valid_i = 0; key_value_i = 0; oct_up_i = 0; oct_dn_i = 0;
    endtask

    task automatic press(input int code, input bit glide, input string tag);
        key_valid_i = 1; key_value_i = 4'(code); glide_en_i = glide;
        cyc(tag);
        key_valid_i = 0;
    endtask

    task automatic oct_pulse(input bit up, input bit dn, input string tag);
        oct_up_i = up; oct_dn_i = dn;
        cyc(tag);
        oct_up_i = 0; oct_dn_i = 0;
    endtask

    initial begin
        rst_ni = 0; glide_en_i = 0;
        idle_inputs();
        m_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_all("in_reset");
        @(negedge clk_i);
        rst_ni = 1;
        #1;
        check_all("reset_release");
        chk("reset_div", 32'(div_factor_o), 32'd128);

        // Immediate load of C at octave 0.
        press(0, 0, "key0");
        chk("key0_div", 32'(div_factor_o), 32'd1920);
        chk("key0_active", 32'(note_active_o), 32'd1);

        // Two octaves up (retargets the sounding note), then A# = 135 << 1.
        oct_pulse(1, 0, "oct_up1");
        oct_pulse(1, 0, "oct_up2");
        press(10, 0, "key10");
        chk("key10_oct2_div", 32'(div_factor_o), 32'd270);
        oct_pulse(1, 0, "oct_up3");
        chk("oct3_div", 32'(div_factor_o), 32'd135);
        oct_pulse(1, 0, "oct_up4");
        chk("oct_sat_div", 32'(div_factor_o), 32'd135);

        // Codes 13-15 are discarded.
        press(14, 0, "key14");
        chk("key14_div", 32'(div_factor_o), 32'd135);

        // Back to octave 0, reload C, then glide down to B (1016).
        repeat (3) oct_pulse(0, 1, "oct_dn");
        press(0, 0, "key0_again");
        chk("reload_div", 32'(div_factor_o), 32'd1920);
        glide_en_i = 1;
        press(11, 1, "glide_start");
        chk("glide_busy", 32'(busy_o), 32'd1);
        chk("glide_ready", 32'(key_ready_o), 32'd0);
        for (int k = 1; k <= 57; k++) begin
            repeat (GLIDE_TICKS) cyc("glide");
            chk("glide_step_div", 32'(div_factor_o),
                32'((1920 - 16 * k < 1016) ? 1016 : 1920 - 16 * k));
        end
        chk("glide_done_busy", 32'(busy_o), 32'd0);

        // Rest keeps pitch; up+down together leaves octave at 0.
        press(12, 1, "rest");
        chk("rest_active", 32'(note_active_o), 32'd0);
        chk("rest_div", 32'(div_factor_o), 32'd1016);
        oct_pulse(1, 1, "oct_both");
        press(0, 0, "key0_after_both");
        chk("oct_both_div", 32'(div_factor_o), 32'd1920);

        // Reset asserted mid-glide takes effect at once.
        press(11, 1, "glide2");
        repeat (10) cyc("glide2_run");
        #2;
        rst_ni = 0;
        #1;
        m_reset();
        check_all("mid_glide_reset");
        chk("mid_reset_div", 32'(div_factor_o), 32'd128);
        @(negedge clk_i);
        rst_ni = 1;
        @(posedge clk_i);
        #1;
        press(4, 0, "key4");
        chk("key4_div", 32'(div_factor_o), 32'd1520);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            key_valid_i = ($urandom_range(0, 99) < 30);
            key_value_i = 4'($urandom_range(0, 15));
            oct_up_i    = ($urandom_range(0, 99) < 8);
            oct_dn_i    = ($urandom_range(0, 99) < 8);
            glide_en_i  = ($urandom_range(0, 99) < 85);
            cyc("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
